alu_op_sequencer: RTL and testbench
===================================

Name: alu_op_sequencer

Overview:
Sequencing stage wrapped around the 4-bit combinational ALU.
- Upstream: accepts {opcode, a, b} requests over a valid/ready handshake and drives them onto the ALU operand inputs from registers.
- Downstream: captures the ALU's 8-bit result plus carry/overflow and queues them in a small result FIFO with its own valid/ready output.
- Decouples pin-level request timing from ALU evaluation and absorbs consumer backpressure.

Parameters:
ALU_LATENCY, 0, extra cycles the ALU needs before its result is sampled; legal range 0..3.
FIFO_DEPTH, 2, result FIFO entries; legal values 2 or 4.

Ports:
clk  input  1  single clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
in_valid  input  1  request present
in_ready  output  1  request accepted when in_valid & in_ready at clk edge
in_opcode  input  3  ALU opcode (000 ADD, 001 SUB, 010 MUL, 011 DIV, 100 AND, 101 OR, 110 XOR, 111 NOT)
in_a  input  4  operand A
in_b  input  4  operand B
alu_opcode  output  3  registered opcode to ALU
alu_a  output  4  registered operand A to ALU
alu_b  output  4  registered operand B to ALU
alu_result  input  8  ALU result {hi nibble, lo nibble}
alu_carry  input  1  ALU carry_out
alu_overflow  input  1  ALU overflow
out_valid  output  1  FIFO head valid
out_ready  input  1  consumer pops head when out_valid & out_ready at clk edge
out_opcode  output  3  opcode of head entry
out_result  output  8  result of head entry
out_carry  output  1  carry of head entry
out_overflow  output  1  overflow of head entry
out_divz  output  1  divide-by-zero flag of head entry
busy  output  1  state != IDLE or FIFO non-empty

Behaviour:
- Reset (rst=1 at edge):
  - state=IDLE; wait counter=0; alu_opcode/alu_a/alu_b=0.
  - FIFO emptied; pointers=0.
  - out_valid=0; busy=0.
  - in_ready=0 while rst is high.
- Reset mid-operation: the in-flight request and all queued entries are discarded; no partial push.
- FSM states: IDLE, EXEC.
  - IDLE: in_ready = (count < FIFO_DEPTH). On accept, latch in_* into alu_*, load counter=ALU_LATENCY, go to EXEC.
  - EXEC: in_ready=0; alu_* held stable. counter!=0 -> decrement. counter==0 -> at this edge push {alu_opcode, alu_result, alu_carry, alu_overflow, divz=0}, return to IDLE.
- Timing, accept at edge E0:
  - push at edge E(ALU_LATENCY+1); out_valid high in the following cycle if the FIFO was empty.
  - Max throughput is one request per ALU_LATENCY+2 cycles.
- Only one request is in flight. Admission requires count<FIFO_DEPTH, so a push never overflows.
- FIFO:
  - Circular buffer; pointers wrap modulo FIFO_DEPTH; count ranges 0..FIFO_DEPTH.
  - Push and pop on the same edge: both performed, count unchanged. This is legal at any count, including full.
  - Pop when empty: ignored.
  - out_* reflect the head entry combinationally; all out_* fields are 0 when empty.
  - Entries are never reordered.
- FIFO full in IDLE: in_ready=0 until a pop. A pop edge frees a slot; in_ready rises in the next cycle.
- No arithmetic is performed here; result width and flags pass through unmodified.

Optional Feature:
Macro ALU_DIVZERO_TRAP_EN.
- Defined: an accept in IDLE with in_opcode=011 and in_b=0 does not enter EXEC.
  - alu_* registers are not updated.
  - The same edge pushes {opcode=011, result=8'h00, carry=0, overflow=0, divz=1}.
  - State stays IDLE; admission requires count<FIFO_DEPTH as usual.
  - The entry is visible one cycle after accept, regardless of ALU_LATENCY.
- Not defined: DIV by zero is issued to the ALU like any other request; out_divz is tied to 0.

Test Plan:
- Reset then ADD a=9,b=8, ALU stub returns result=8'h01, carry=1, overflow=1, ALU_LATENCY=0 -> alu_a=9, alu_b=8 one cycle after accept; out_valid high two cycles after accept with out_result=8'h01, out_carry=1, out_overflow=1, out_opcode=000.
- ALU_LATENCY=2, MUL a=15,b=15, stub returns 8'hE1 -> alu_* stable for 3 EXEC cycles; push at accept+3 edges; out_result=8'hE1.
- FIFO_DEPTH=2, out_ready=0, three back-to-back requests (AND, OR, XOR) -> first two captured in order; in_ready=0 with count=2; third accepted only after out_ready=1 pops one; pop order AND, OR, XOR.
- FIFO full with out_ready=1 held while a new request completes -> push and pop on the same edge, count stays 2, no entry lost or duplicated.
- Assert rst during EXEC with one entry queued -> next cycle out_valid=0, busy=0, alu_*=0; in_ready=1 after rst deasserts; the aborted request never appears at the output.
- ALU_DIVZERO_TRAP_EN defined, DIV a=7,b=0 -> out_divz=1, out_result=8'h00 one cycle after accept, alu_* unchanged. Macro undefined -> request goes through EXEC and out_divz=0.

Source files
------------

// File: rtl/alu_op_sequencer_if.sv
// Request / ALU-operand / result-FIFO bundle for alu_op_sequencer.
// The slave modport is the sequencer's view; the master modport is the surrounding logic.
interface alu_op_sequencer_if;
   logic       in_valid;
   logic       in_ready;
   logic [2:0] in_opcode;
   logic [3:0] in_a;
   logic [3:0] in_b;

   logic [2:0] alu_opcode;
   logic [3:0] alu_a;
   logic [3:0] alu_b;
   logic [7:0] alu_result;
   logic       alu_carry;
   logic       alu_overflow;

   logic       out_valid;
   logic       out_ready;
   logic [2:0] out_opcode;
   logic [7:0] out_result;
   logic       out_carry;
   logic       out_overflow;
   logic       out_divz;

   logic       busy;

   modport slave (
      input  in_valid, in_opcode, in_a, in_b,
      input  alu_result, alu_carry, alu_overflow,
      input  out_ready,
      output in_ready,
      output alu_opcode, alu_a, alu_b,
      output out_valid, out_opcode, out_result, out_carry, out_overflow, out_divz,
      output busy
   );

   modport master (
      output in_valid, in_opcode, in_a, in_b,
      output alu_result, alu_carry, alu_overflow,
      output out_ready,
      input  in_ready,
      input  alu_opcode, alu_a, alu_b,
      input  out_valid, out_opcode, out_result, out_carry, out_overflow, out_divz,
      input  busy
   );
endinterface

// File: rtl/alu_op_sequencer.sv
// Registers one request at a time onto the 4-bit ALU and queues its results in a small FIFO.
// Optional macro ALU_DIVZERO_TRAP_EN: divide-by-zero requests bypass the ALU and push a divz entry.
//
// state | meaning
// IDLE  | waiting for a request; ready while the result FIFO has room
// EXEC  | operands held on the ALU; counting down latency, push on terminal count
module alu_op_sequencer #(
   parameter int unsigned ALU_LATENCY = 0,
   parameter int unsigned FIFO_DEPTH  = 2
) (
   input logic                clk,
   input logic                rst,
   alu_op_sequencer_if.slave  bus
);

   typedef enum logic {IDLE = 1'b0, EXEC = 1'b1} state_t;

   localparam int unsigned PW = (FIFO_DEPTH > 2) ? 2 : 1;
   localparam int unsigned CW = PW + 1;
   localparam logic [1:0]    LAT_C   = 2'(ALU_LATENCY);
   localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
   localparam logic [PW-1:0] LAST_C  = PW'(FIFO_DEPTH - 1);
   localparam logic [2:0]    OP_DIV  = 3'b011;

   typedef struct packed {
      logic [2:0] op;
      logic [7:0] res;
      logic       carry;
      logic       ovf;
`ifdef ALU_DIVZERO_TRAP_EN
      logic       divz;
`endif
   } entry_t;

   state_t        state_q, state_d;
   logic [1:0]    cnt_q, cnt_d;
   logic [2:0]    alu_opcode_q, alu_opcode_d;
   logic [3:0]    alu_a_q, alu_a_d;
   logic [3:0]    alu_b_q, alu_b_d;
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   entry_t        mem_q [FIFO_DEPTH];
   entry_t        mem_d [FIFO_DEPTH];

   logic   in_ready_c;
   logic   accept;
   logic   trap;
   logic   push;
   logic   pop;
   entry_t push_entry;
   entry_t head;
   logic   not_empty;

   function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
      return (p == LAST_C) ? '0 : p + PW'(1);
   endfunction

   always_comb begin
      in_ready_c = !rst && (state_q == IDLE) && (count_q < DEPTH_C);
      accept     = bus.in_valid && in_ready_c;
      trap       = 1'b0;
`ifdef ALU_DIVZERO_TRAP_EN
      trap       = accept && (bus.in_opcode == OP_DIV) && (bus.in_b == 4'd0);
`endif

      state_d      = state_q;
      cnt_d        = cnt_q;
      alu_opcode_d = alu_opcode_q;
      alu_a_d      = alu_a_q;
      alu_b_d      = alu_b_q;
      push         = 1'b0;

      case (state_q)
         IDLE: begin
            if (trap) begin
               push = 1'b1;
            end else if (accept) begin
               alu_opcode_d = bus.in_opcode;
               alu_a_d      = bus.in_a;
               alu_b_d      = bus.in_b;
               cnt_d        = LAT_C;
               state_d      = EXEC;
            end
         end
         EXEC: begin
            if (cnt_q != 2'd0) begin
               cnt_d = cnt_q - 2'd1;
            end else begin
               push    = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      push_entry.op    = alu_opcode_q;
      push_entry.res   = bus.alu_result;
      push_entry.carry = bus.alu_carry;
      push_entry.ovf   = bus.alu_overflow;
`ifdef ALU_DIVZERO_TRAP_EN
      push_entry.divz  = 1'b0;
      if (trap) begin
         push_entry.op    = OP_DIV;
         push_entry.res   = 8'h00;
         push_entry.carry = 1'b0;
         push_entry.ovf   = 1'b0;
         push_entry.divz  = 1'b1;
      end
`endif
   end

   // Result FIFO; admission control guarantees a push never finds it full
   // unless a pop happens on the same edge.
   always_comb begin
      not_empty = (count_q != '0);
      pop       = bus.out_ready && not_empty;
      mem_d     = mem_q;
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      count_d   = count_q;

      if (push) begin
         mem_d[wr_ptr_q] = push_entry;
         wr_ptr_d        = ptr_next(wr_ptr_q);
      end
      if (pop) begin
         rd_ptr_d = ptr_next(rd_ptr_q);
      end
      if (push && !pop) begin
         count_d = count_q + CW'(1);
      end else if (pop && !push) begin
         count_d = count_q - CW'(1);
      end

      head = not_empty ? mem_q[rd_ptr_q] : '0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         alu_opcode_q <= '0;
         alu_a_q      <= '0;
         alu_b_q      <= '0;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         count_q      <= '0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         alu_opcode_q <= alu_opcode_d;
         alu_a_q      <= alu_a_d;
         alu_b_q      <= alu_b_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         count_q      <= count_d;
      end
   end

   // Storage needs no reset: the empty FIFO masks every stale entry.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   assign bus.in_ready     = in_ready_c;
   assign bus.alu_opcode   = alu_opcode_q;
   assign bus.alu_a        = alu_a_q;
   assign bus.alu_b        = alu_b_q;
   assign bus.out_valid    = not_empty;
   assign bus.out_opcode   = head.op;
   assign bus.out_result   = head.res;
   assign bus.out_carry    = head.carry;
   assign bus.out_overflow = head.ovf;
`ifdef ALU_DIVZERO_TRAP_EN
   assign bus.out_divz     = head.divz;
`else
   assign bus.out_divz     = 1'b0;
`endif
   assign bus.busy         = (state_q != IDLE) || not_empty;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer: latency-0/depth-2 and latency-2/depth-4 instances
// with the ALU replaced by bench-driven stub values.
module tb_alu_op_sequencer;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   alu_op_sequencer_if if0 ();
   alu_op_sequencer_if if2 ();

   alu_op_sequencer #(.ALU_LATENCY(0), .FIFO_DEPTH(2)) dut0 (.clk(clk), .rst(rst), .bus(if0));
   alu_op_sequencer #(.ALU_LATENCY(2), .FIFO_DEPTH(4)) dut2 (.clk(clk), .rst(rst), .bus(if2));

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic [2:0] op;
      logic [3:0] a;
      logic [3:0] b;
      logic [7:0] stub_res;
      logic       stub_c;
      logic       stub_o;
      logic [7:0] exp_res;
      logic       exp_c;
      logic       exp_o;
      logic       exp_divz;
      logic       trap;
   } vec_t;

   localparam int NV = 7;
   vec_t vecs [NV];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic stub0(input logic [7:0] r, input logic c, input logic o);
      if0.alu_result   = r;
      if0.alu_carry    = c;
      if0.alu_overflow = o;
   endtask

   // Holds the request until accepted; returns one step after the accept edge.
   task automatic send0(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
      int n;
      n = 0;
      if0.in_valid  = 1'b1;
      if0.in_opcode = op;
      if0.in_a      = a;
      if0.in_b      = b;
      while (!if0.in_ready && n < 40) begin
         tick();
         n++;
      end
      if (n >= 40) chk("accept_timeout", {31'd0, if0.in_ready}, 32'd1);
      tick();
      if0.in_valid = 1'b0;
   endtask

   // Latency-0 request including its push edge.
   task automatic req0(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
      send0(op, a, b);
      tick();
   endtask

   task automatic pop0();
      if0.out_ready = 1'b1;
      tick();
      if0.out_ready = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0] = '{3'b000, 4'd9,  4'd8,  8'h01, 1'b1, 1'b1, 8'h01, 1'b1, 1'b1, 1'b0, 1'b0};
      vecs[1] = '{3'b001, 4'd3,  4'd5,  8'hFE, 1'b1, 1'b0, 8'hFE, 1'b1, 1'b0, 1'b0, 1'b0};
      vecs[2] = '{3'b010, 4'd15, 4'd15, 8'hE1, 1'b0, 1'b0, 8'hE1, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[3] = '{3'b100, 4'hA,  4'hC,  8'h08, 1'b0, 1'b0, 8'h08, 1'b0, 1'b0, 1'b0, 1'b0};
`ifdef ALU_DIVZERO_TRAP_EN
      vecs[4] = '{3'b011, 4'd7,  4'd0,  8'h3C, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1};
`else
      vecs[4] = '{3'b011, 4'd7,  4'd0,  8'h3C, 1'b0, 1'b1, 8'h3C, 1'b0, 1'b1, 1'b0, 1'b0};
`endif
      vecs[5] = '{3'b111, 4'd5,  4'd0,  8'h0A, 1'b0, 1'b0, 8'h0A, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[6] = '{3'b011, 4'd9,  4'd2,  8'h04, 1'b0, 1'b0, 8'h04, 1'b0, 1'b0, 1'b0, 1'b0};

      rst = 1'b1;
      if0.in_valid = 1'b0; if0.in_opcode = '0; if0.in_a = '0; if0.in_b = '0;
      if0.out_ready = 1'b0; stub0(8'h00, 1'b0, 1'b0);
      if2.in_valid = 1'b0; if2.in_opcode = '0; if2.in_a = '0; if2.in_b = '0;
      if2.out_ready = 1'b0; if2.alu_result = '0; if2.alu_carry = 1'b0; if2.alu_overflow = 1'b0;

      // reset state
      if0.in_valid = 1'b1;
      tick(); tick();
      chk("rst_in_ready",   {31'd0, if0.in_ready}, 32'd0);
      chk("rst_out_valid",  {31'd0, if0.out_valid}, 32'd0);
      chk("rst_busy",       {31'd0, if0.busy}, 32'd0);
      chk("rst_alu_a",      {28'd0, if0.alu_a}, 32'd0);
      chk("rst_alu_b",      {28'd0, if0.alu_b}, 32'd0);
      chk("rst_alu_opcode", {29'd0, if0.alu_opcode}, 32'd0);
      chk("rst_in_ready2",  {31'd0, if2.in_ready}, 32'd0);
      if0.in_valid = 1'b0;
      rst = 1'b0;
      #1;
      chk("post_rst_in_ready", {31'd0, if0.in_ready}, 32'd1);

      // table-driven single requests on the latency-0 instance
      for (int i = 0; i < NV; i++) begin
         logic [3:0] prev_a;
         logic [3:0] prev_b;
         logic [2:0] prev_op;
         prev_a  = if0.alu_a;
         prev_b  = if0.alu_b;
         prev_op = if0.alu_opcode;
         stub0(vecs[i].stub_res, vecs[i].stub_c, vecs[i].stub_o);
         send0(vecs[i].op, vecs[i].a, vecs[i].b);
         if (vecs[i].trap) begin
            chk($sformatf("v%0d_trap_alu_a", i),  {28'd0, if0.alu_a}, {28'd0, prev_a});
            chk($sformatf("v%0d_trap_alu_b", i),  {28'd0, if0.alu_b}, {28'd0, prev_b});
            chk($sformatf("v%0d_trap_alu_op", i), {29'd0, if0.alu_opcode}, {29'd0, prev_op});
            chk($sformatf("v%0d_trap_in_ready", i), {31'd0, if0.in_ready}, 32'd1);
         end else begin
            chk($sformatf("v%0d_alu_op", i), {29'd0, if0.alu_opcode}, {29'd0, vecs[i].op});
            chk($sformatf("v%0d_alu_a", i),  {28'd0, if0.alu_a}, {28'd0, vecs[i].a});
            chk($sformatf("v%0d_alu_b", i),  {28'd0, if0.alu_b}, {28'd0, vecs[i].b});
            chk($sformatf("v%0d_early_valid", i), {31'd0, if0.out_valid}, 32'd0);
            chk($sformatf("v%0d_exec_in_ready", i), {31'd0, if0.in_ready}, 32'd0);
            tick();
         end
         chk($sformatf("v%0d_out_valid", i),  {31'd0, if0.out_valid}, 32'd1);
         chk($sformatf("v%0d_out_opcode", i), {29'd0, if0.out_opcode}, {29'd0, vecs[i].op});
         chk($sformatf("v%0d_out_result", i), {24'd0, if0.out_result}, {24'd0, vecs[i].exp_res});
         chk($sformatf("v%0d_out_carry", i),  {31'd0, if0.out_carry}, {31'd0, vecs[i].exp_c});
         chk($sformatf("v%0d_out_ovf", i),    {31'd0, if0.out_overflow}, {31'd0, vecs[i].exp_o});
         chk($sformatf("v%0d_out_divz", i),   {31'd0, if0.out_divz}, {31'd0, vecs[i].exp_divz});
         pop0();
         chk($sformatf("v%0d_popped_valid", i),  {31'd0, if0.out_valid}, 32'd0);
         chk($sformatf("v%0d_empty_result", i),  {24'd0, if0.out_result}, 32'd0);
         chk($sformatf("v%0d_idle_busy", i),     {31'd0, if0.busy}, 32'd0);
      end

      // backpressure: fill depth-2 FIFO, third request waits for a pop
      stub0(8'h11, 1'b0, 1'b0); req0(3'b100, 4'h1, 4'h2);
      stub0(8'h22, 1'b0, 1'b0); req0(3'b101, 4'h3, 4'h4);
      chk("full_in_ready", {31'd0, if0.in_ready}, 32'd0);
      chk("full_head_op",  {29'd0, if0.out_opcode}, 32'd4);
      stub0(8'h33, 1'b0, 1'b0);
      if0.in_valid = 1'b1; if0.in_opcode = 3'b110; if0.in_a = 4'h5; if0.in_b = 4'h6;
      tick(); tick();
      chk("full_still_blocked", {31'd0, if0.in_ready}, 32'd0);
      chk("full_no_accept",     {29'd0, if0.alu_opcode}, 32'd5);
      pop0();
      chk("after_pop_in_ready", {31'd0, if0.in_ready}, 32'd1);
      chk("after_pop_head",     {24'd0, if0.out_result}, 32'h22);
      tick();
      if0.in_valid = 1'b0;
      chk("xor_alu_op", {29'd0, if0.alu_opcode}, 32'd6);
      tick();
      chk("order_or_op",  {29'd0, if0.out_opcode}, 32'd5);
      pop0();
      chk("order_xor_op",  {29'd0, if0.out_opcode}, 32'd6);
      chk("order_xor_res", {24'd0, if0.out_result}, 32'h33);
      pop0();
      chk("order_empty", {31'd0, if0.out_valid}, 32'd0);

      // push and pop on the same edge
      stub0(8'h44, 1'b0, 1'b0); req0(3'b101, 4'h7, 4'h8);
      stub0(8'h55, 1'b1, 1'b0); send0(3'b100, 4'h9, 4'hA);
      if0.out_ready = 1'b1;
      tick();
      if0.out_ready = 1'b0;
      chk("pp_valid",  {31'd0, if0.out_valid}, 32'd1);
      chk("pp_head",   {24'd0, if0.out_result}, 32'h55);
      chk("pp_carry",  {31'd0, if0.out_carry}, 32'd1);
      chk("pp_in_ready", {31'd0, if0.in_ready}, 32'd1);
      pop0();
      chk("pp_no_dup", {31'd0, if0.out_valid}, 32'd0);

      // reset during EXEC with one entry queued
      stub0(8'h66, 1'b0, 1'b0); req0(3'b101, 4'h1, 4'h1);
      stub0(8'h77, 1'b0, 1'b0); send0(3'b000, 4'h3, 4'h4);
      chk("pre_rst_alu_a", {28'd0, if0.alu_a}, 32'd3);
      rst = 1'b1;
      #1;
      chk("rst_hi_in_ready", {31'd0, if0.in_ready}, 32'd0);
      tick();
      chk("mid_rst_out_valid", {31'd0, if0.out_valid}, 32'd0);
      chk("mid_rst_busy",      {31'd0, if0.busy}, 32'd0);
      chk("mid_rst_alu_a",     {28'd0, if0.alu_a}, 32'd0);
      chk("mid_rst_alu_op",    {29'd0, if0.alu_opcode}, 32'd0);
      rst = 1'b0;
      #1;
      chk("mid_rst_in_ready", {31'd0, if0.in_ready}, 32'd1);
      tick(); tick();
      chk("aborted_never_out", {31'd0, if0.out_valid}, 32'd0);

      // latency-2 instance: operands held for three EXEC cycles
      if2.alu_result = 8'hE1; if2.alu_carry = 1'b0; if2.alu_overflow = 1'b0;
      if2.in_valid = 1'b1; if2.in_opcode = 3'b010; if2.in_a = 4'hF; if2.in_b = 4'hF;
      chk("l2_in_ready", {31'd0, if2.in_ready}, 32'd1);
      tick();
      if2.in_valid = 1'b0;
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("l2_c%0d_alu_op", k), {29'd0, if2.alu_opcode}, 32'd2);
         chk($sformatf("l2_c%0d_alu_a", k),  {28'd0, if2.alu_a}, 32'hF);
         chk($sformatf("l2_c%0d_alu_b", k),  {28'd0, if2.alu_b}, 32'hF);
         chk($sformatf("l2_c%0d_valid", k),  {31'd0, if2.out_valid}, 32'd0);
         chk($sformatf("l2_c%0d_in_ready", k), {31'd0, if2.in_ready}, 32'd0);
         tick();
      end
      chk("l2_out_valid",  {31'd0, if2.out_valid}, 32'd1);
      chk("l2_out_result", {24'd0, if2.out_result}, 32'hE1);
      chk("l2_out_opcode", {29'd0, if2.out_opcode}, 32'd2);
      chk("l2_in_ready_back", {31'd0, if2.in_ready}, 32'd1);
      if2.out_ready = 1'b1; tick(); if2.out_ready = 1'b0;
      chk("l2_popped", {31'd0, if2.out_valid}, 32'd0);

      // latency-2 instance: divide by zero
      if2.alu_result = 8'h5A; if2.alu_carry = 1'b0; if2.alu_overflow = 1'b0;
      if2.in_valid = 1'b1; if2.in_opcode = 3'b011; if2.in_a = 4'd7; if2.in_b = 4'd0;
      tick();
      if2.in_valid = 1'b0;
`ifdef ALU_DIVZERO_TRAP_EN
      chk("dz_valid",  {31'd0, if2.out_valid}, 32'd1);
      chk("dz_divz",   {31'd0, if2.out_divz}, 32'd1);
      chk("dz_result", {24'd0, if2.out_result}, 32'h00);
      chk("dz_opcode", {29'd0, if2.out_opcode}, 32'd3);
      chk("dz_alu_a_kept", {28'd0, if2.alu_a}, 32'hF);
      chk("dz_alu_op_kept", {29'd0, if2.alu_opcode}, 32'd2);
`else
      chk("dz_alu_op",   {29'd0, if2.alu_opcode}, 32'd3);
      chk("dz_alu_b",    {28'd0, if2.alu_b}, 32'd0);
      chk("dz_early",    {31'd0, if2.out_valid}, 32'd0);
      tick(); tick(); tick();
      chk("dz_valid",  {31'd0, if2.out_valid}, 32'd1);
      chk("dz_divz",   {31'd0, if2.out_divz}, 32'd0);
      chk("dz_result", {24'd0, if2.out_result}, 32'h5A);
`endif
      if2.out_ready = 1'b1; tick(); if2.out_ready = 1'b0;
      chk("dz_popped", {31'd0, if2.out_valid}, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
